// File: rtl/counter_modn_if.sv
// counter_modn_if: bus bundle for counter_modn.
//   master : bench/controller side; drives w, up_dn, load, load_val and
//            observes counter, wrap, at_term, wrap_cnt (and counter_gray
//            when COUNTER_GRAY_OUT_EN is defined).
//   slave  : counter side; mirror image of master.
// Optional feature macro: COUNTER_GRAY_OUT_EN adds counter_gray.
interface counter_modn_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);
  logic              w;
  logic              up_dn;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  counter;
  logic              wrap;
  logic              at_term;
  logic [WRAP_W-1:0] wrap_cnt;
`ifdef COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0]  counter_gray;

  modport master (output w, up_dn, load, load_val,
                  input  counter, wrap, at_term, wrap_cnt, counter_gray);
  modport slave  (input  w, up_dn, load, load_val,
                  output counter, wrap, at_term, wrap_cnt, counter_gray);
`else
  modport master (output w, up_dn, load, load_val,
                  input  counter, wrap, at_term, wrap_cnt);
  modport slave  (input  w, up_dn, load, load_val,
                  output counter, wrap, at_term, wrap_cnt);
`endif
endinterface

// File: rtl/counter_modn.sv
// counter_modn: modulo-MOD up/down counter with count enable, synchronous
// parallel load (clamped to MOD-1), optional saturation, a one-cycle wrap
// pulse, a combinational terminal-count flag and a saturating wrap counter.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   bus      counter_modn_if.slave
//              w, up_dn, load, load_val   (in)
//              counter, wrap, wrap_cnt    (out, registered)
//              at_term                    (out, combinational)
//              counter_gray               (out, registered, optional)
//
// Optional feature macro: COUNTER_GRAY_OUT_EN. When defined, counter_gray
// carries the Gray code of counter, registered on the same edge.
module counter_modn #(
  parameter int MOD      = 6,
  parameter int WIDTH    = $clog2(MOD),
  parameter bit SATURATE = 1'b0,
  parameter int WRAP_W   = 8
) (
  input logic           clk,
  input logic           rst,
  counter_modn_if.slave bus
);

  localparam logic [WIDTH-1:0]  MAX_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WCNT_MAX = '1;
  localparam logic [WRAP_W-1:0] WCNT_ONE = WRAP_W'(1);

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (bus.w) begin
      if (cnt_q > MAX_VAL) begin
        // Recovery from an illegal state: restart at zero, not a wrap.
        cnt_d = '0;
      end else if (bus.up_dn) begin
        if (cnt_q == MAX_VAL) begin
          if (!SATURATE) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          if (!SATURATE) begin
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
    wcnt_d = (wrap_d && (wcnt_q != WCNT_MAX)) ? wcnt_q + WCNT_ONE : wcnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign bus.counter  = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wcnt_q;
  assign bus.at_term  = bus.up_dn ? (cnt_q == MAX_VAL) : (cnt_q == '0);

`ifdef COUNTER_GRAY_OUT_EN
  // Encode the next value so the Gray output lands on the same edge as counter.
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk) begin
    if (!rst) gray_q <= '0;
    else      gray_q <= cnt_d ^ (cnt_d >> 1);
  end

  assign bus.counter_gray = gray_q;
`endif

endmodule

// File: tb/tb_counter_modn.sv
module tb_counter_modn;

  typedef struct {
    int cnt;
    bit wrap;
    int wcnt;
  } mst_t;

  typedef struct {
    bit r, w, up, ld;
    int lv;
    int cnt;
    bit wrap;
    int wc;
    bit term;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_s, rst_m;
  int   checks = 0;
  int   errors = 0;
  mst_t ma, ms;
  bit   ua, us;

  always #5 clk = ~clk;

  counter_modn_if #(.WIDTH(3), .WRAP_W(8)) ia ();
  counter_modn_if #(.WIDTH(3), .WRAP_W(8)) is ();
  counter_modn_if #(.WIDTH(1), .WRAP_W(2)) im ();

  counter_modn #(.MOD(6)) dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  counter_modn #(.MOD(6), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst_s), .bus(is.slave));
  counter_modn #(.MOD(2), .WRAP_W(2)) dut_m (.clk(clk), .rst(rst_m), .bus(im.slave));

`ifdef COUNTER_GRAY_OUT_EN
  logic rst_g;
  counter_modn_if #(.WIDTH(3), .WRAP_W(8)) ig ();
  counter_modn #(.MOD(8)) dut_g (.clk(clk), .rst(rst_g), .bus(ig.slave));
`endif

  // Reference: position on a circle of mod slots; stepping off either end
  // either lands on the opposite end (a wrap) or is refused (saturation).
  function automatic mst_t mnext(mst_t s, int mod, bit sat, int wmax,
                                 bit rstn, bit w, bit up, bit ld, int lv);
    mst_t n;
    int   t;
    n      = s;
    n.wrap = 1'b0;
    if (!rstn) begin
      n.cnt  = 0;
      n.wcnt = 0;
      return n;
    end
    if (ld) begin
      n.cnt = (lv < mod) ? lv : mod - 1;
    end else if (w) begin
      t = s.cnt + (up ? 1 : -1);
      if (t < 0 || t >= mod) begin
        if (!sat) begin
          n.cnt  = (t + mod) % mod;
          n.wrap = 1'b1;
        end
      end else begin
        n.cnt = t;
      end
    end
    if (n.wrap && n.wcnt < wmax) n.wcnt = n.wcnt + 1;
    return n;
  endfunction

  function automatic vec_t v(bit r, bit w, bit up, bit ld, int lv,
                             int cnt, bit wrap, int wc, bit term);
    vec_t x;
    x = '{r, w, up, ld, lv, cnt, wrap, wc, term};
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(bit r, bit w, bit up, bit ld, int lv);
    rst_a = r; ia.w = w; ia.up_dn = up; ia.load = ld; ia.load_val = 3'(lv);
    ua = up;
    ma = mnext(ma, 6, 1'b0, 255, r, w, up, ld, lv);
  endtask

  task automatic set_s(bit r, bit w, bit up, bit ld, int lv);
    rst_s = r; is.w = w; is.up_dn = up; is.load = ld; is.load_val = 3'(lv);
    us = up;
    ms = mnext(ms, 6, 1'b1, 255, r, w, up, ld, lv);
  endtask

  task automatic chk_model(string tag, int cnt, int wrap, int wc, int term, mst_t m, bit up);
    chk({tag, " counter"}, cnt, m.cnt);
    chk({tag, " wrap"}, wrap, int'(m.wrap));
    chk({tag, " wrap_cnt"}, wc, m.wcnt);
    chk({tag, " at_term"}, term, int'(up ? (m.cnt == 5) : (m.cnt == 0)));
  endtask

  initial begin
    vec_t tbl[$];
    int   exp_c;

    rst_a = 1'b0; rst_s = 1'b0; rst_m = 1'b0;
    ia.w = 1'b0; ia.up_dn = 1'b1; ia.load = 1'b0; ia.load_val = '0;
    is.w = 1'b0; is.up_dn = 1'b1; is.load = 1'b0; is.load_val = '0;
    im.w = 1'b0; im.up_dn = 1'b1; im.load = 1'b0; im.load_val = '0;
    ma = '{0, 1'b0, 0};
    ms = '{0, 1'b0, 0};
`ifdef COUNTER_GRAY_OUT_EN
    rst_g = 1'b0;
    ig.w = 1'b0; ig.up_dn = 1'b1; ig.load = 1'b0; ig.load_val = '0;
`endif

    // Directed table on the default mod-6 counter.
    tbl.push_back(v(0,0,1,0,0, 0,0,0,0));
    for (int k = 1; k <= 5; k++) tbl.push_back(v(1,1,1,0,0, k,0,0,(k == 5)));
    tbl.push_back(v(1,1,1,0,0, 0,1,1,0));
    tbl.push_back(v(1,1,1,0,0, 1,0,1,0));
    tbl.push_back(v(1,1,1,0,0, 2,0,1,0));
    tbl.push_back(v(1,1,1,0,0, 3,0,1,0));
    for (int k = 0; k < 5; k++) tbl.push_back(v(1,0,1,0,0, 3,0,1,0));
    tbl.push_back(v(1,1,0,0,0, 2,0,1,0));
    tbl.push_back(v(1,1,0,0,0, 1,0,1,0));
    tbl.push_back(v(1,1,0,0,0, 0,0,1,1));
    tbl.push_back(v(1,1,0,0,0, 5,1,2,0));
    tbl.push_back(v(1,1,0,0,0, 4,0,2,0));
    tbl.push_back(v(1,1,0,1,4, 4,0,2,0));
    tbl.push_back(v(1,1,0,1,7, 5,0,2,0));
    tbl.push_back(v(1,0,1,0,0, 5,0,2,1));
    tbl.push_back(v(1,1,0,0,0, 4,0,2,0));
    tbl.push_back(v(1,1,1,0,0, 5,0,2,1));
    tbl.push_back(v(1,1,1,0,0, 0,1,3,0));
    for (int k = 1; k <= 4; k++) tbl.push_back(v(1,1,1,0,0, k,0,3,0));
    tbl.push_back(v(0,1,1,1,2, 0,0,0,0));
    tbl.push_back(v(1,1,1,0,0, 1,0,0,0));

    @(negedge clk);
    foreach (tbl[i]) begin
      set_a(tbl[i].r, tbl[i].w, tbl[i].up, tbl[i].ld, tbl[i].lv);
      tick();
      chk($sformatf("tbl[%0d] counter", i), int'(ia.counter), tbl[i].cnt);
      chk($sformatf("tbl[%0d] wrap", i), int'(ia.wrap), int'(tbl[i].wrap));
      chk($sformatf("tbl[%0d] wrap_cnt", i), int'(ia.wrap_cnt), tbl[i].wc);
      chk($sformatf("tbl[%0d] at_term", i), int'(ia.at_term), int'(tbl[i].term));
    end

    // Saturating mod-6: climb to 5 and stay, then descend to 0 and stay.
    set_s(0, 0, 1, 0, 0);
    tick();
    chk("sat reset counter", int'(is.counter), 0);
    for (int k = 1; k <= 10; k++) begin
      set_s(1, 1, 1, 0, 0);
      tick();
      exp_c = (k < 5) ? k : 5;
      chk($sformatf("sat up%0d counter", k), int'(is.counter), exp_c);
      chk($sformatf("sat up%0d wrap", k), int'(is.wrap), 0);
      chk($sformatf("sat up%0d at_term", k), int'(is.at_term), int'(exp_c == 5));
    end
    for (int k = 1; k <= 8; k++) begin
      set_s(1, 1, 0, 0, 0);
      tick();
      exp_c = (5 - k > 0) ? 5 - k : 0;
      chk($sformatf("sat dn%0d counter", k), int'(is.counter), exp_c);
      chk($sformatf("sat dn%0d wrap", k), int'(is.wrap), 0);
      chk($sformatf("sat dn%0d at_term", k), int'(is.at_term), int'(exp_c == 0));
    end
    chk("sat wrap_cnt", int'(is.wrap_cnt), 0);

    // Mod-2 with a 2-bit wrap counter: wrap every other step, count sticks at 3.
    tick();
    rst_m = 1'b1; im.w = 1'b1; im.up_dn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("m2 step%0d counter", k), int'(im.counter), k % 2);
      chk($sformatf("m2 step%0d wrap", k), int'(im.wrap), int'(k % 2 == 0));
      chk($sformatf("m2 step%0d wrap_cnt", k), int'(im.wrap_cnt), (k / 2 < 3) ? k / 2 : 3);
    end
    im.w = 1'b0;

`ifdef COUNTER_GRAY_OUT_EN
    begin
      int gexp[8];
      gexp = '{1, 3, 2, 6, 7, 5, 4, 0};
      tick();
      chk("gray reset", int'(ig.counter_gray), 0);
      rst_g = 1'b1; ig.w = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk($sformatf("gray step%0d", k), int'(ig.counter_gray), gexp[k]);
      end
      ig.w = 1'b0;
    end
`endif

    // Random traffic on both mod-6 variants against the reference model.
    for (int k = 0; k < 400; k++) begin
      set_a((k == 0) ? 1'b0 : ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
      set_s((k == 0) ? 1'b0 : ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
      tick();
      chk_model($sformatf("rnd a%0d", k), int'(ia.counter), int'(ia.wrap),
                int'(ia.wrap_cnt), int'(ia.at_term), ma, ua);
      chk_model($sformatf("rnd s%0d", k), int'(is.counter), int'(is.wrap),
                int'(is.wrap_cnt), int'(is.at_term), ms, us);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
